// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// pipe_hazard_ctrl_if : hazard/redirect control bundle between pipeline and
//                       the stall/flush sequencer.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if #(
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
);
    logic             iwait;
    logic             dwait;
    logic             load_use;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             stall_m;
    logic             flush_d;
    logic             flush_e;
    logic             flush_w;
    logic             pc_redirect_valid;
    logic [PC_W-1:0]  pc_redirect;
    logic             redir_pending;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] redirect_count;

    // Pipeline side: reports waits/hazards, consumes the controls
    modport master (
        output iwait, dwait, load_use, redirect_valid, redirect_pc,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
        input  pc_redirect_valid, pc_redirect, redir_pending,
        input  stall_cycles, redirect_count
    );

    modport slave (
        input  iwait, dwait, load_use, redirect_valid, redirect_pc,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
        output pc_redirect_valid, pc_redirect, redir_pending,
        output stall_cycles, redirect_count
    );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall/flush sequencer with redirect-pending FSM for the
//                    5-stage pipeline. Optional perf counters: PIPE_HAZARD_PERF_CNT_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = 64'h8000_0000,
    parameter int              CNT_W    = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [PC_W-1:0] r_pendPc;
    logic [PC_W-1:0] w_nextPendPc;

    logic            w_stallF, w_stallD, w_stallE, w_stallM;
    logic            w_flushD, w_flushE, w_flushW;
    logic            w_pcRedirValid;
    logic [PC_W-1:0] w_pcRedir;

    always_comb begin
        w_stallF       = 1'b0;
        w_stallD       = 1'b0;
        w_stallE       = 1'b0;
        w_stallM       = 1'b0;
        w_flushD       = 1'b0;
        w_flushE       = 1'b0;
        w_flushW       = 1'b0;
        w_pcRedirValid = 1'b0;
        w_pcRedir      = '0;
        w_nextState    = r_state;
        w_nextPendPc   = r_pendPc;

        if (reset) begin
            w_flushD    = 1'b1;
            w_flushE    = 1'b1;
            w_flushW    = 1'b1;
            w_nextState = RUN;
        end else if (hz.dwait) begin
            // Execute is frozen; any redirect re-presents once memory returns
            w_stallF = 1'b1;
            w_stallD = 1'b1;
            w_stallE = 1'b1;
            w_stallM = 1'b1;
            w_flushW = 1'b1;
        end else if (hz.redirect_valid) begin
            w_flushD = 1'b1;
            w_flushE = 1'b1;
            if (hz.iwait) begin
                w_stallF     = 1'b1;
                w_nextState  = PEND;
                w_nextPendPc = hz.redirect_pc;
            end else begin
                w_pcRedirValid = 1'b1;
                w_pcRedir      = hz.redirect_pc;
                w_nextState    = RUN;
            end
        end else if (r_state == PEND) begin
            // Wrong-path fetch is discarded whether or not it has returned
            w_flushD = 1'b1;
            if (hz.iwait) begin
                w_stallF = 1'b1;
            end else begin
                w_pcRedirValid = 1'b1;
                w_pcRedir      = r_pendPc;
                w_nextState    = RUN;
            end
        end else if (hz.load_use) begin
            w_stallF = 1'b1;
            w_stallD = 1'b1;
            w_flushE = 1'b1;
        end else if (hz.iwait) begin
            w_stallF = 1'b1;
            w_flushD = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUN;
            r_pendPc <= RESET_PC;
        end else begin
            r_state  <= w_nextState;
            r_pendPc <= w_nextPendPc;
        end
    end

    assign hz.stall_f           = w_stallF;
    assign hz.stall_d           = w_stallD;
    assign hz.stall_e           = w_stallE;
    assign hz.stall_m           = w_stallM;
    assign hz.flush_d           = w_flushD;
    assign hz.flush_e           = w_flushE;
    assign hz.flush_w           = w_flushW;
    assign hz.pc_redirect_valid = w_pcRedirValid;
    assign hz.pc_redirect       = w_pcRedir;
    assign hz.redir_pending     = !reset && (r_state == PEND);

`ifdef PIPE_HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_stallCycles;
    logic [CNT_W-1:0] r_redirectCount;
    logic             w_stallEvent;

    assign w_stallEvent = hz.dwait | hz.iwait | hz.load_use | (r_state == PEND);

    // Saturating counters: stick at all-ones rather than wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCycles   <= '0;
            r_redirectCount <= '0;
        end else begin
            if (w_stallEvent && (r_stallCycles != '1))
                r_stallCycles <= r_stallCycles + c_ONE;
            if (w_pcRedirValid && (r_redirectCount != '1))
                r_redirectCount <= r_redirectCount + c_ONE;
        end
    end

    assign hz.stall_cycles   = r_stallCycles;
    assign hz.redirect_count = r_redirectCount;
`else
    assign hz.stall_cycles   = '0;
    assign hz.redirect_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : directed + randomized check of pipe_hazard_ctrl
//                       against an event-level reference model.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int          c_PC_W     = 64;
    localparam int          c_CNT_W    = 8;
    localparam logic [63:0] c_RESET_PC = 64'h8000_0000;

    logic clk;
    logic reset;
    int   nVec;
    int   nBad;

    pipe_hazard_ctrl_if #(.PC_W(c_PC_W), .CNT_W(c_CNT_W)) hz ();

    pipe_hazard_ctrl #(
        .PC_W    (c_PC_W),
        .RESET_PC(c_RESET_PC),
        .CNT_W   (c_CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {A_RESET, A_MEMWAIT, A_PARK, A_JUMP, A_PENDWAIT, A_PENDISSUE,
                      A_LOADUSE, A_FETCHWAIT, A_IDLE} act_t;

    logic        mPend;
    logic [63:0] mPendPc;
    int          mStall;
    int          mRedir;

    initial begin
        mPend = 1'b0; mPendPc = c_RESET_PC; mStall = 0; mRedir = 0;
    end

    function automatic act_t classify();
        if (reset)                 return A_RESET;
        if (hz.dwait)              return A_MEMWAIT;
        if (hz.redirect_valid)     return hz.iwait ? A_PARK : A_JUMP;
        if (mPend)                 return hz.iwait ? A_PENDWAIT : A_PENDISSUE;
        if (hz.load_use)           return A_LOADUSE;
        if (hz.iwait)              return A_FETCHWAIT;
        return A_IDLE;
    endfunction

    // Order: stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, pc_redirect_valid
    function automatic logic [7:0] flagsFor(input act_t a);
        case (a)
            A_RESET:     return 8'b0000_1110;
            A_MEMWAIT:   return 8'b1111_0010;
            A_PARK:      return 8'b1000_1100;
            A_JUMP:      return 8'b0000_1101;
            A_PENDWAIT:  return 8'b1000_1000;
            A_PENDISSUE: return 8'b0000_1001;
            A_LOADUSE:   return 8'b1100_0100;
            A_FETCHWAIT: return 8'b1000_1000;
            default:     return 8'b0000_0000;
        endcase
    endfunction

    always @(negedge clk) begin
        act_t        a;
        logic [7:0]  f;
        logic [63:0] epc;
        int          satMax;
        a   = classify();
        f   = flagsFor(a);
        epc = (a == A_JUMP) ? hz.redirect_pc : (a == A_PENDISSUE) ? mPendPc : 64'h0;
        chk("stall_f",  {63'h0, hz.stall_f},  {63'h0, f[7]});
        chk("stall_d",  {63'h0, hz.stall_d},  {63'h0, f[6]});
        chk("stall_e",  {63'h0, hz.stall_e},  {63'h0, f[5]});
        chk("stall_m",  {63'h0, hz.stall_m},  {63'h0, f[4]});
        chk("flush_d",  {63'h0, hz.flush_d},  {63'h0, f[3]});
        chk("flush_e",  {63'h0, hz.flush_e},  {63'h0, f[2]});
        chk("flush_w",  {63'h0, hz.flush_w},  {63'h0, f[1]});
        chk("pc_redirect_valid", {63'h0, hz.pc_redirect_valid}, {63'h0, f[0]});
        chk("pc_redirect", hz.pc_redirect, epc);
        chk("redir_pending", {63'h0, hz.redir_pending}, {63'h0, (!reset && mPend)});
        chk("stall_cycles",   {56'h0, hz.stall_cycles},   64'(mStall));
        chk("redirect_count", {56'h0, hz.redirect_count}, 64'(mRedir));

        // advance model state to what follows the coming clock edge
        satMax = (1 << c_CNT_W) - 1;
        if (a == A_RESET) begin
            mPend = 1'b0; mPendPc = c_RESET_PC; mStall = 0; mRedir = 0;
        end else begin
`ifdef PIPE_HAZARD_PERF_CNT_EN
            if ((hz.dwait || hz.iwait || hz.load_use || mPend) && mStall < satMax) mStall++;
            if (f[0] && mRedir < satMax) mRedir++;
`endif
            if (a == A_PARK) begin mPend = 1'b1; mPendPc = hz.redirect_pc; end
            if (a == A_JUMP || a == A_PENDISSUE) mPend = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rs, input logic iw, input logic dw, input logic lu,
                         input logic rv, input logic [63:0] rpc);
        @(posedge clk);
        #1;
        reset = rs; hz.iwait = iw; hz.dwait = dw; hz.load_use = lu;
        hz.redirect_valid = rv; hz.redirect_pc = rpc;
        #1;
    endtask

    initial begin
        reset = 1'b1; hz.iwait = 1'b0; hz.dwait = 1'b0; hz.load_use = 1'b0;
        hz.redirect_valid = 1'b0; hz.redirect_pc = '0;
        nVec = 0; nBad = 0;

        // 1: reset then idle
        drive(1, 0, 0, 0, 0, 0);
        chk("rst flush_w", {63'h0, hz.flush_w}, 64'h1);
        chk("rst stall_f", {63'h0, hz.stall_f}, 64'h0);
        drive(0, 0, 0, 0, 0, 0);
        chk("idle flush_d", {63'h0, hz.flush_d}, 64'h0);
        chk("idle pending", {63'h0, hz.redir_pending}, 64'h0);

        // 6a: 5 fetch waits + 2 direct redirects
        repeat (5) drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 64'h8000_0010);
        drive(0, 0, 0, 0, 1, 64'h8000_0020);
        drive(0, 0, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_PERF_CNT_EN
        chk("cnt stall 5",  {56'h0, hz.stall_cycles},   64'd5);
        chk("cnt redir 2",  {56'h0, hz.redirect_count}, 64'd2);
`else
        chk("cnt stall off", {56'h0, hz.stall_cycles},   64'd0);
        chk("cnt redir off", {56'h0, hz.redirect_count}, 64'd0);
`endif

        // 2: direct redirect
        drive(0, 0, 0, 0, 1, 64'h8000_0100);
        chk("redir now valid", {63'h0, hz.pc_redirect_valid}, 64'h1);
        chk("redir now pc", hz.pc_redirect, 64'h8000_0100);
        drive(0, 0, 0, 0, 0, 0);
        chk("redir after idle", {63'h0, hz.pc_redirect_valid}, 64'h0);

        // 3: redirect parked behind an outstanding fetch
        drive(0, 1, 0, 0, 1, 64'h8000_0200);
        chk("park prv", {63'h0, hz.pc_redirect_valid}, 64'h0);
        repeat (3) drive(0, 1, 0, 0, 0, 0);
        chk("pend pending", {63'h0, hz.redir_pending}, 64'h1);
        drive(0, 0, 0, 0, 0, 0);
        chk("pend issue pc", hz.pc_redirect, 64'h8000_0200);
        drive(0, 0, 0, 0, 0, 0);
        chk("pend back run", {63'h0, hz.redir_pending}, 64'h0);

        // 4: memory wait while parked
        drive(0, 1, 0, 0, 1, 64'h8000_0200);
        drive(0, 0, 1, 0, 0, 0);
        chk("dwait stall_m", {63'h0, hz.stall_m}, 64'h1);
        drive(0, 0, 1, 0, 0, 0);
        chk("dwait no redir", {63'h0, hz.pc_redirect_valid}, 64'h0);
        drive(0, 0, 0, 0, 0, 0);
        chk("post dwait pc", hz.pc_redirect, 64'h8000_0200);

        // 5: load-use vs redirect
        drive(0, 1, 0, 1, 0, 0);
        chk("lu flush_d", {63'h0, hz.flush_d}, 64'h0);
        chk("lu stall_d", {63'h0, hz.stall_d}, 64'h1);
        drive(0, 0, 0, 1, 1, 64'h8000_0300);
        chk("lu+redir stall_d", {63'h0, hz.stall_d}, 64'h0);
        chk("lu+redir flush_d", {63'h0, hz.flush_d}, 64'h1);

        // 6b: drive the stall counter into saturation
        repeat (300) drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_PERF_CNT_EN
        chk("cnt saturate", {56'h0, hz.stall_cycles}, 64'hFF);
`else
        chk("cnt sat off", {56'h0, hz.stall_cycles}, 64'h0);
`endif

        // random phase
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(63) == 0),
                  ($urandom_range(99) < 40),
                  ($urandom_range(99) < 15),
                  ($urandom_range(99) < 20),
                  ($urandom_range(99) < 15),
                  {$urandom, $urandom});
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule

`default_nettype wire
